tlb_writer: RTL and testbench

//  Write-side controller for the 8-entry TLB storage (44-bit entries:
//  {vpn[43:24], ppn[23:4], valid[3], pr[2], rw[1], pcd[0]}). Accepts fill

---
 rtl/tlb_writer.sv | 197 +++++++++++++++++++
 tb/tb_tlb_writer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_writer.sv
// Write-side controller for the 8-entry TLB: looks up, picks a victim and drives the single write port.
// Optional whole-TLB flush is compiled in when TLB_WR_FLUSH_EN is defined.
module tlb_writer #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3,
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [VPN_W-1:0]           tlb_pn0,
  input  logic [VPN_W-1:0]           tlb_pn1,
  input  logic [VPN_W-1:0]           tlb_pn2,
  input  logic [VPN_W-1:0]           tlb_pn3,
  input  logic [VPN_W-1:0]           tlb_pn4,
  input  logic [VPN_W-1:0]           tlb_pn5,
  input  logic [VPN_W-1:0]           tlb_pn6,
  input  logic [VPN_W-1:0]           tlb_pn7,
  input  logic [ENTRIES-1:0]         tlb_vld_vec,
  input  logic                       fill_valid,
  output logic                       fill_ready,
  input  logic [VPN_W-1:0]           fill_vpn,
  input  logic [PPN_W-1:0]           fill_ppn,
  input  logic                       fill_pr,
  input  logic                       fill_rw,
  input  logic                       fill_pcd,
  output logic                       fill_done,
  output logic [IDX_W-1:0]           fill_idx,
  output logic                       fill_hit,
  input  logic                       flush_req,
  output logic                       flush_done,
  output logic                       tlb_wr_en,
  output logic [IDX_W-1:0]           tlb_wr_addr,
  output logic [VPN_W+PPN_W+3:0]     tlb_wr_data
);

  localparam int ENT_W = VPN_W + PPN_W + 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITE,
    S_DONE
`ifdef TLB_WR_FLUSH_EN
    , S_FLUSH,
    S_FLUSH_DONE
`endif
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [VPN_W-1:0]   pn_arr [ENTRIES];

  logic [VPN_W-1:0]   vpn_p0;
  logic [PPN_W-1:0]   ppn_p0;
  logic [2:0]         attr_p0;
  logic [IDX_W-1:0]   idx_p1;
  logic               hit_p1;

  logic               any_hit, any_inv;
  logic [IDX_W-1:0]   hit_idx, inv_idx, sel_idx;
  logic               accept;

`ifdef TLB_WR_FLUSH_EN
  logic [IDX_W-1:0]   flush_cnt;
`else
  logic               flush_unused;
  assign flush_unused = flush_req;
`endif

  assign pn_arr[0] = tlb_pn0;
  assign pn_arr[1] = tlb_pn1;
  assign pn_arr[2] = tlb_pn2;
  assign pn_arr[3] = tlb_pn3;
  assign pn_arr[4] = tlb_pn4;
  assign pn_arr[5] = tlb_pn5;
  assign pn_arr[6] = tlb_pn6;
  assign pn_arr[7] = tlb_pn7;

  assign accept = fill_valid && fill_ready;

  // Lowest matching valid entry wins; otherwise lowest free slot; otherwise round-robin victim.
  always_comb begin
    any_hit = 1'b0;
    any_inv = 1'b0;
    hit_idx = '0;
    inv_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!any_hit && tlb_vld_vec[i] && pn_arr[i] == vpn_p0) begin
        any_hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!any_inv && !tlb_vld_vec[i]) begin
        any_inv = 1'b1;
        inv_idx = IDX_W'(i);
      end
    end
    sel_idx = any_hit ? hit_idx : (any_inv ? inv_idx : rr_ptr);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
`ifdef TLB_WR_FLUSH_EN
        if (flush_req)       state_nx = S_FLUSH;
        else if (fill_valid) state_nx = S_LOOKUP;
`else
        if (fill_valid)      state_nx = S_LOOKUP;
`endif
      end
      S_LOOKUP:              state_nx = S_WRITE;
      S_WRITE:               state_nx = S_DONE;
      S_DONE:                state_nx = S_IDLE;
`ifdef TLB_WR_FLUSH_EN
      S_FLUSH:      if (flush_cnt == IDX_W'(ENTRIES - 1)) state_nx = S_FLUSH_DONE;
      S_FLUSH_DONE:          state_nx = S_IDLE;
`endif
      default:               state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
`ifdef TLB_WR_FLUSH_EN
      flush_cnt <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == S_LOOKUP && !any_hit && !any_inv) rr_ptr <= rr_ptr + 1'b1;
`ifdef TLB_WR_FLUSH_EN
      if (state == S_FLUSH) begin
        flush_cnt <= flush_cnt + 1'b1;
        if (flush_cnt == IDX_W'(ENTRIES - 1)) rr_ptr <= '0;
      end
`endif
    end
  end

  // Stage p0: captured request; stage p1: lookup result
  always_ff @(posedge clk) begin
    if (accept) begin
      vpn_p0  <= fill_vpn;
      ppn_p0  <= fill_ppn;
      attr_p0 <= {fill_pr, fill_rw, fill_pcd};
    end
    if (state == S_LOOKUP) begin
      idx_p1 <= sel_idx;
      hit_p1 <= any_hit;
    end
  end

  // Reset forces every output low, so an abandoned fill never reaches the write port.
  always_comb begin
    fill_ready  = 1'b0;
    fill_done   = 1'b0;
    fill_idx    = '0;
    fill_hit    = 1'b0;
    flush_done  = 1'b0;
    tlb_wr_en   = 1'b0;
    tlb_wr_addr = '0;
    tlb_wr_data = '0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
`ifdef TLB_WR_FLUSH_EN
          fill_ready = !flush_req;
`else
          fill_ready = 1'b1;
`endif
        end
        S_WRITE: begin
          tlb_wr_en   = 1'b1;
          tlb_wr_addr = idx_p1;
          tlb_wr_data = {vpn_p0, ppn_p0, 1'b1, attr_p0};
        end
        S_DONE: begin
          fill_done = 1'b1;
          fill_idx  = idx_p1;
          fill_hit  = hit_p1;
        end
`ifdef TLB_WR_FLUSH_EN
        S_FLUSH: begin
          tlb_wr_en   = 1'b1;
          tlb_wr_addr = flush_cnt;
          tlb_wr_data = ENT_W'(0);
        end
        S_FLUSH_DONE: flush_done = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_writer.sv
// Bench for tlb_writer: a cycle-indexed schedule of expected outputs plus directed literal checks.
module tb_tlb_writer;

  localparam bit FLUSH_EN =
`ifdef TLB_WR_FLUSH_EN
    1'b1;
`else
    1'b0;
`endif
  localparam int NC = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] pn [8];
  logic [7:0]  vld_vec;
  logic        fill_valid, fill_ready;
  logic [19:0] fill_vpn, fill_ppn;
  logic        fill_pr, fill_rw, fill_pcd;
  logic        fill_done, fill_hit;
  logic [2:0]  fill_idx;
  logic        flush_req, flush_done;
  logic        tlb_wr_en;
  logic [2:0]  tlb_wr_addr;
  logic [43:0] tlb_wr_data;

  always #5 clk = ~clk;

  tlb_writer dut (
    .clk(clk), .rst(rst),
    .tlb_pn0(pn[0]), .tlb_pn1(pn[1]), .tlb_pn2(pn[2]), .tlb_pn3(pn[3]),
    .tlb_pn4(pn[4]), .tlb_pn5(pn[5]), .tlb_pn6(pn[6]), .tlb_pn7(pn[7]),
    .tlb_vld_vec(vld_vec),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_vpn(fill_vpn), .fill_ppn(fill_ppn),
    .fill_pr(fill_pr), .fill_rw(fill_rw), .fill_pcd(fill_pcd),
    .fill_done(fill_done), .fill_idx(fill_idx), .fill_hit(fill_hit),
    .flush_req(flush_req), .flush_done(flush_done),
    .tlb_wr_en(tlb_wr_en), .tlb_wr_addr(tlb_wr_addr), .tlb_wr_data(tlb_wr_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idle_from = 0;
  int rr_m = 0;

  logic        e_wr_en   [NC];
  logic [2:0]  e_wr_addr [NC];
  logic [43:0] e_wr_data [NC];
  logic        e_done    [NC];
  logic [2:0]  e_idx     [NC];
  logic        e_hit     [NC];
  logic        e_fdone   [NC];

  logic [2:0]  last_addr, last_idx;
  logic [43:0] last_data;
  logic        last_hit;
  int last_wr_cyc, last_done_cyc;
  int wr_cnt, zero_wr_cnt, done_cnt, fdone_cnt;
  int done_hist[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Model: each accepted request books its outputs on absolute cycle numbers.
  always @(posedge clk) begin : model
    int c;
    int sel;
    bit h;
    c = cyc;
    if (rst) begin
      for (int k = c + 1; k < c + 14 && k < NC; k++) begin
        e_wr_en[k] = 0; e_wr_addr[k] = 0; e_wr_data[k] = 0;
        e_done[k] = 0; e_idx[k] = 0; e_hit[k] = 0; e_fdone[k] = 0;
      end
      idle_from = c + 1;
      rr_m = 0;
    end else if (c >= idle_from && c + 12 < NC) begin
      if (FLUSH_EN && flush_req) begin
        for (int k = 0; k < 8; k++) begin
          e_wr_en[c+1+k] = 1; e_wr_addr[c+1+k] = 3'(k); e_wr_data[c+1+k] = '0;
        end
        e_fdone[c+9] = 1;
        idle_from = c + 10;
        rr_m = 0;
      end else if (fill_valid) begin
        sel = -1; h = 0;
        for (int i = 0; i < 8; i++)
          if (sel < 0 && vld_vec[i] && pn[i] == fill_vpn) begin sel = i; h = 1; end
        for (int i = 0; i < 8; i++)
          if (sel < 0 && !vld_vec[i]) sel = i;
        if (sel < 0) begin sel = rr_m; rr_m = (rr_m + 1) % 8; end
        e_wr_en[c+2] = 1; e_wr_addr[c+2] = 3'(sel);
        e_wr_data[c+2] = {fill_vpn, fill_ppn, 1'b1, fill_pr, fill_rw, fill_pcd};
        e_done[c+3] = 1; e_idx[c+3] = 3'(sel); e_hit[c+3] = h;
        idle_from = c + 4;
      end
    end
    cyc = c + 1;
  end

  always @(negedge clk) begin : compare
    int c;
    logic er;
    c = cyc;
    if (c < NC) begin
      er = !rst && c >= idle_from && !(FLUSH_EN && flush_req);
      if (rst) begin
        chk("reset_outputs", {fill_ready, fill_done, fill_idx, fill_hit, flush_done,
                              tlb_wr_en, tlb_wr_addr, tlb_wr_data}, 64'h0);
      end else begin
        chk("fill_ready", fill_ready, er);
        chk("wr_port", {tlb_wr_en, tlb_wr_addr, tlb_wr_data}, {e_wr_en[c], e_wr_addr[c], e_wr_data[c]});
        chk("done", {fill_done, fill_idx, fill_hit}, {e_done[c], e_idx[c], e_hit[c]});
        chk("flush_done", flush_done, e_fdone[c]);
      end
      if (tlb_wr_en) begin
        wr_cnt++; last_addr = tlb_wr_addr; last_data = tlb_wr_data; last_wr_cyc = c;
        if (tlb_wr_data == 44'h0) zero_wr_cnt++;
      end
      if (fill_done) begin
        done_cnt++; last_idx = fill_idx; last_hit = fill_hit; last_done_cyc = c;
        done_hist.push_back(int'(fill_idx));
      end
      if (flush_done) fdone_cnt++;
    end
  end

  task automatic fill_go(input logic [19:0] vpn, input logic [19:0] ppn,
                         input logic pr, input logic rw, input logic pcd, output int acc);
    bit got;
    fill_vpn = vpn; fill_ppn = ppn; fill_pr = pr; fill_rw = rw; fill_pcd = pcd;
    fill_valid = 1; got = 0; acc = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (fill_ready) begin got = 1; acc = cyc; end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    fill_valid = 0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int acc, s, n;
    int accs[$];
    for (int k = 0; k < NC; k++) begin
      e_wr_en[k] = 0; e_wr_addr[k] = 0; e_wr_data[k] = 0;
      e_done[k] = 0; e_idx[k] = 0; e_hit[k] = 0; e_fdone[k] = 0;
    end
    wr_cnt = 0; zero_wr_cnt = 0; done_cnt = 0; fdone_cnt = 0;
    last_addr = 0; last_data = 0; last_idx = 0; last_hit = 0;
    last_wr_cyc = 0; last_done_cyc = 0;
    rst = 1; vld_vec = 8'h00; fill_valid = 0; flush_req = 0;
    fill_vpn = 0; fill_ppn = 0; fill_pr = 0; fill_rw = 0; fill_pcd = 0;
    for (int i = 0; i < 8; i++) pn[i] = 20'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", fill_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", fill_ready, 1);
    @(posedge clk); #1;

    // Empty TLB: first free slot 0
    fill_go(20'h12345, 20'hABCDE, 1, 1, 0, acc);
    settle();
    chk("t1_addr", last_addr, 3'd0);
    chk("t1_data", last_data, 44'h12345ABCDEE);
    chk("t1_idx", last_idx, 3'd0);
    chk("t1_hit", last_hit, 0);
    chk("t1_wr_latency", last_wr_cyc - acc, 2);
    chk("t1_done_latency", last_done_cyc - acc, 3);

    // Full TLB with a matching VPN in entry 3
    vld_vec = 8'hFF;
    for (int i = 0; i < 8; i++) pn[i] = 20'h00100 + 20'(i);
    pn[3] = 20'h12345;
    fill_go(20'h12345, 20'h00001, 0, 0, 1, acc);
    settle();
    chk("t2_addr", last_addr, 3'd3);
    chk("t2_data", last_data, 44'h12345000019);
    chk("t2_hit", last_hit, 1);

    // Nine back-to-back misses on a full TLB walk the round-robin pointer
    pn[3] = 20'h00103;
    done_hist.delete();
    fill_vpn = 20'hFFFFF; fill_ppn = 20'h55555; fill_pr = 1; fill_rw = 0; fill_pcd = 0;
    fill_valid = 1; n = 0;
    for (int k = 0; k < 60 && n < 9; k++) begin
      @(negedge clk);
      if (fill_ready) begin n++; accs.push_back(cyc); end
    end
    chk("t3_accepts", n, 9);
    @(posedge clk); #1;
    fill_valid = 0;
    settle();
    chk("t3_done_count", done_hist.size(), 9);
    for (int i = 0; i < 9 && i < done_hist.size(); i++) chk("t3_idx_seq", done_hist[i], i % 8);
    for (int i = 1; i < accs.size(); i++) chk("t3_accept_spacing", accs[i] - accs[i-1], 4);

    // Entry 3 free: lowest invalid chosen, pointer left at 1
    vld_vec = 8'hF7;
    fill_go(20'hFFFFF, 20'h22222, 0, 1, 1, acc);
    settle();
    chk("t4_idx", last_idx, 3'd3);
    chk("t4_hit", last_hit, 0);
    vld_vec = 8'hFF;
    fill_go(20'hFFFFF, 20'h33333, 0, 1, 1, acc);
    settle();
    chk("t4_rr_unchanged", last_idx, 3'd1);

    // Flush and fill requested together
    wr_cnt = 0; zero_wr_cnt = 0; fdone_cnt = 0; done_cnt = 0;
    s = cyc;
    fill_vpn = 20'hFFFFF; fill_ppn = 20'h44444; fill_pr = 1; fill_rw = 1; fill_pcd = 1;
    flush_req = 1; fill_valid = 1; acc = -1;
    @(negedge clk);
    if (fill_ready) acc = cyc;
    @(posedge clk); #1;
    flush_req = 0;
    for (int k = 0; k < 20 && acc < 0; k++) begin
      @(negedge clk);
      if (fill_ready) acc = cyc;
      @(posedge clk); #1;
    end
    fill_valid = 0;
    settle();
    chk("t5_accept_delay", acc - s, FLUSH_EN ? 10 : 0);
    chk("t5_zero_writes", zero_wr_cnt, FLUSH_EN ? 8 : 0);
    chk("t5_flush_done", fdone_cnt, FLUSH_EN ? 1 : 0);
    chk("t5_fill_idx", last_idx, FLUSH_EN ? 3'd0 : 3'd2);
    chk("t5_fill_done", done_cnt, 1);

    // Reset during the write cycle abandons the fill
    wr_cnt = 0; done_cnt = 0;
    fill_go(20'h0ABCD, 20'h66666, 1, 0, 0, acc);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_write", wr_cnt, 0);
    chk("t6_no_done", done_cnt, 0);
    @(negedge clk);
    chk("t6_ready", fill_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
